// File: rtl/snake_msg_rx_if.sv
// snake_pkg: shared SnakeWars types (direction encoding carried in 6-bit payloads).
// snake_msg_rx_if: UART RX FIFO read port, as seen by the message decoder.
//   rx_empty : FIFO empty flag (FIFO side drives)
//   r_data   : FIFO head byte, valid while rx_empty=0 (FIFO side drives)
//   rd_uart  : one-cycle pop strobe (decoder drives)
// Modports: master = FIFO side, slave = decoder side.

package snake_pkg;
    typedef enum logic [5:0] {
        NONE  = 6'd0,
        UP    = 6'd1,
        DOWN  = 6'd2,
        LEFT  = 6'd3,
        RIGHT = 6'd4
    } direction;
endpackage

interface snake_msg_rx_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;

    modport master (output rx_empty, output r_data, input rd_uart);
    modport slave  (input rx_empty, input r_data, output rd_uart);
endinterface

// File: rtl/snake_msg_rx.sv
// snake_msg_rx: SnakeWars receive-side message decoder.
// Drains the UART RX FIFO, parses opcode framing ([7:6] opcode, [5:0] payload;
// 00 error, 01 direction, 10 collision, 11 click + raw Y byte) and emits
// one-cycle event pulses with decoded payloads.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   en          : decode enable; when 0 bytes are still drained but no pulses
//                 or output updates occur
//   uart        : snake_msg_rx_if.slave (rx_empty, r_data in; rd_uart out)
//   dir_out     : last received direction      dir_valid   : pulse
//   coll_code   : last collision code          coll_valid  : pulse
//   click_x/y   : last click coordinates       click_valid : pulse
//   err         : pulse on opcode 00 or click second-byte timeout
//   busy        : high while the FSM is not in IDLE
// Optional feature macro SNAKE_RX_ERRCNT_EN: adds err_cnt[7:0], a saturating
// count of error events (counted even when en=0).

module snake_msg_rx
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    snake_msg_rx_if.slave uart,
    output direction      dir_out,
    output logic          dir_valid,
    output logic [1:0]    coll_code,
    output logic          coll_valid,
    output logic [5:0]    click_x,
    output logic [7:0]    click_y,
    output logic          click_valid,
    output logic          err,
    output logic          busy
`ifdef SNAKE_RX_ERRCNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, POP_HDR, WAIT_Y, POP_Y} state_t;

    state_t           state_q;
    logic [7:0]       hdr_q;
    logic [5:0]       x_q;
    logic [7:0]       y_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rd_q;
    logic             busy_q;
    direction         dir_q;
    logic             dir_valid_q;
    logic [1:0]       coll_q;
    logic             coll_valid_q;
    logic [5:0]       click_x_q;
    logic [7:0]       click_y_q;
    logic             click_valid_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            hdr_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            rd_q          <= 1'b0;
            busy_q        <= 1'b0;
            dir_q         <= NONE;
            dir_valid_q   <= 1'b0;
            coll_q        <= '0;
            coll_valid_q  <= 1'b0;
            click_x_q     <= '0;
            click_y_q     <= '0;
            click_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rd_q          <= 1'b0;
            dir_valid_q   <= 1'b0;
            coll_valid_q  <= 1'b0;
            click_valid_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!uart.rx_empty) begin
                        hdr_q   <= uart.r_data;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= POP_HDR;
                    end
                end
                POP_HDR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    case (hdr_q[7:6])
                        2'b01: begin
                            if (en) begin
                                dir_q       <= direction'(hdr_q[5:0]);
                                dir_valid_q <= 1'b1;
                            end
                        end
                        2'b10: begin
                            if (en) begin
                                coll_q       <= hdr_q[1:0];
                                coll_valid_q <= 1'b1;
                            end
                        end
                        2'b00: err_q <= en;
                        2'b11: begin
                            x_q     <= hdr_q[5:0];
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= WAIT_Y;
                        end
                    endcase
                end
                WAIT_Y: begin
                    if (!uart.rx_empty) begin
                        y_q     <= uart.r_data;
                        rd_q    <= 1'b1;
                        state_q <= POP_Y;
                    end else if (cnt_q == CNT_LAST) begin
                        // Second click byte never arrived: drop x, report error.
                        err_q   <= en;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                POP_Y: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (en) begin
                        click_x_q     <= x_q;
                        click_y_q     <= y_q;
                        click_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uart.rd_uart = rd_q;
    assign busy         = busy_q;
    assign dir_out      = dir_q;
    assign dir_valid    = dir_valid_q;
    assign coll_code    = coll_q;
    assign coll_valid   = coll_valid_q;
    assign click_x      = click_x_q;
    assign click_y      = click_y_q;
    assign click_valid  = click_valid_q;
    assign err          = err_q;

`ifdef SNAKE_RX_ERRCNT_EN
    // Error event independent of en, so suppressed errors are still counted.
    logic       err_evt;
    logic [7:0] err_cnt_q;

    assign err_evt = ((state_q == POP_HDR) && (hdr_q[7:6] == 2'b00)) ||
                     ((state_q == WAIT_Y) && uart.rx_empty && (cnt_q == CNT_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (err_evt && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_snake_msg_rx.sv
// Self-checking bench for snake_msg_rx: a queue-based UART FIFO model feeds
// bytes, a message-level model predicts events into a scoreboard, and a
// negedge monitor pops and compares each event and the held output values.
`timescale 1ns/1ps

module tb_snake_msg_rx;
    import snake_pkg::*;

    localparam int unsigned TMO = 64;
    localparam logic [1:0] K_DIR = 2'd0, K_COLL = 2'd1, K_CLICK = 2'd2, K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    snake_msg_rx_if uart ();

    direction   dir_out;
    logic       dir_valid;
    logic [1:0] coll_code;
    logic       coll_valid;
    logic [5:0] click_x;
    logic [7:0] click_y;
    logic       click_valid;
    logic       err;
    logic       busy;
`ifdef SNAKE_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    snake_msg_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .uart       (uart),
        .dir_out    (dir_out),
        .dir_valid  (dir_valid),
        .coll_code  (coll_code),
        .coll_valid (coll_valid),
        .click_x    (click_x),
        .click_y    (click_y),
        .click_valid(click_valid),
        .err        (err),
        .busy       (busy)
`ifdef SNAKE_RX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    exp_t       expq[$];
    logic [7:0] fifo[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int rd_cyc = 0;
    int ev_cyc = 0;
    int exp_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Message-level prediction: what the game logic should see for one message.
    task automatic issue(input logic [7:0] hdr, input logic [7:0] y);
        case (hdr[7:6])
            2'b00: begin
                exp_errs++;
                if (en) expq.push_back('{K_ERR, 8'h00, 8'h00});
            end
            2'b01: if (en) expq.push_back('{K_DIR, {2'b00, hdr[5:0]}, 8'h00});
            2'b10: if (en) expq.push_back('{K_COLL, {6'd0, hdr[1:0]}, 8'h00});
            2'b11: if (en) expq.push_back('{K_CLICK, {2'b00, hdr[5:0]}, y});
        endcase
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(fifo.size() == 0 && uart.rx_empty && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_budget", 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // FIFO model: pop takes effect at the clock edge ending the rd_uart cycle.
    initial begin : fifo_model
        logic pop;
        uart.rx_empty = 1'b1;
        uart.r_data   = 8'h00;
        forever begin
            @(negedge clk);
            pop = uart.rd_uart;
            @(posedge clk);
            #1;
            if (pop && fifo.size() > 0) void'(fifo.pop_front());
            uart.rx_empty = (fifo.size() == 0);
            uart.r_data   = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
        end
    end

    // Monitor: pops the scoreboard on every event pulse and tracks held values.
    initial begin : monitor
        logic [5:0] h_dir;
        logic [1:0] h_coll;
        logic [5:0] h_x;
        logic [7:0] h_y;
        logic       prev_rd;
        int         npulse;
        logic [1:0] gk;
        exp_t       e;
        h_dir = '0; h_coll = '0; h_x = '0; h_y = '0; prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                h_dir = '0; h_coll = '0; h_x = '0; h_y = '0; prev_rd = 1'b0;
            end else begin
                if (uart.rd_uart) begin
                    rd_cnt++;
                    rd_cyc = cyc;
                    chk("rd_while_empty", 32'(uart.rx_empty), 32'd0);
                    chk("rd_back_to_back", 32'(prev_rd), 32'd0);
                end
                prev_rd = uart.rd_uart;
                npulse = 32'(dir_valid) + 32'(coll_valid) + 32'(click_valid) + 32'(err);
                if (npulse != 0) begin
                    ev_cyc = cyc;
                    chk("single_pulse", 32'(npulse), 32'd1);
                    if (expq.size() == 0) begin
                        chk("unexpected_event", 32'({dir_valid, coll_valid, click_valid, err}), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        gk = dir_valid ? K_DIR : coll_valid ? K_COLL : click_valid ? K_CLICK : K_ERR;
                        chk("event_kind", 32'(gk), 32'(e.kind));
                        case (e.kind)
                            K_DIR:   h_dir  = e.a[5:0];
                            K_COLL:  h_coll = e.a[1:0];
                            K_CLICK: begin h_x = e.a[5:0]; h_y = e.b; end
                            default: ;
                        endcase
                    end
                end
                chk("held_outputs", 32'({6'(dir_out), coll_code, click_x, click_y}),
                    32'({h_dir, h_coll, h_x, h_y}));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t0;
        int r0;
        int busy_low;
        int nmsg;
        logic [7:0] hdr;
        logic [7:0] yb;

        repeat (3) @(negedge clk);
        chk("reset_state", 32'({uart.rd_uart, dir_valid, coll_valid, click_valid, err, busy,
                                6'(dir_out), coll_code, click_x, click_y}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Decoding disabled: bytes drained, nothing reported, dir_out stays NONE.
        en = 1'b0;
        r0 = rd_cnt;
        issue(8'h43, 8'h00); push(8'h43);
        issue(8'hC2, 8'h10); push(8'hC2); push(8'h10);
        wait_idle(100);
        chk("en0_pops", 32'(rd_cnt - r0), 32'd3);
        chk("en0_dir_none", 32'(6'(dir_out)), 32'(6'(NONE)));
        en = 1'b1;

        // Single direction byte: latency and one pop.
        t0 = cyc; r0 = rd_cnt;
        issue(8'h44, 8'h00); push(8'h44);
        wait_idle(50);
        chk("dir_rd_cycle", 32'(rd_cyc), 32'(t0 + 2));
        chk("dir_ev_cycle", 32'(ev_cyc), 32'(t0 + 3));
        chk("dir_pops", 32'(rd_cnt - r0), 32'd1);
        chk("dir_fifo_drained", 32'(fifo.size()), 32'd0);

        // Collision then error, back to back at full throughput.
        t0 = cyc; r0 = rd_cnt;
        issue(8'h82, 8'h00); push(8'h82);
        issue(8'h00, 8'h00); push(8'h00);
        wait_idle(50);
        chk("b2b_pops", 32'(rd_cnt - r0), 32'd2);
        chk("b2b_err_cycle", 32'(ev_cyc), 32'(t0 + 5));

        // Click with second byte 50 cycles late; busy held throughout.
        t0 = cyc;
        issue(8'hC5, 8'h20); push(8'hC5);
        repeat (2) @(negedge clk);
        chk("click_busy_pop_hdr", 32'(busy), 32'd1);
        busy_low = 0;
        repeat (50) begin
            @(negedge clk);
            if (!busy) busy_low++;
        end
        push(8'h20);
        wait_idle(50);
        chk("click_busy_gap", 32'(busy_low), 32'd0);
        chk("click_ev_cycle", 32'(ev_cyc), 32'(t0 + 55));

        // Click header followed by silence: timeout error, then a fresh header.
        t0 = cyc;
        exp_errs++;
        expq.push_back('{K_ERR, 8'h00, 8'h00});
        push(8'hC1);
        wait_idle(TMO + 40);
        chk("timeout_ev_cycle", 32'(ev_cyc), 32'(t0 + 3 + TMO));
        issue(8'h41, 8'h00); push(8'h41);
        wait_idle(50);

`ifdef SNAKE_RX_ERRCNT_EN
        en = 1'b0;
        for (int i = 0; i < 260; i++) begin
            issue(8'h00, 8'h00);
            push(8'h00);
        end
        wait_idle(700);
        chk("err_cnt_saturate", 32'(err_cnt), 32'd255);
        en = 1'b1;
`endif

        // Randomized batches of messages, en held per batch.
        for (int b = 0; b < 60; b++) begin
            en = ($urandom_range(3) != 0);
            nmsg = 1 + $urandom_range(3);
            for (int m = 0; m < nmsg; m++) begin
                hdr = 8'($urandom);
                yb  = 8'($urandom);
                issue(hdr, yb);
                push(hdr);
                if (hdr[7:6] == 2'b11) begin
                    repeat ($urandom_range(40)) @(negedge clk);
                    push(yb);
                end else begin
                    repeat ($urandom_range(2)) @(negedge clk);
                end
            end
            wait_idle(400);
        end
        en = 1'b1;

        // Asynchronous reset in the middle of a click.
        push(8'hC7);
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        exp_errs = 0;
        #1;
        chk("async_reset", 32'({uart.rd_uart, dir_valid, coll_valid, click_valid, err, busy,
                                6'(dir_out), coll_code, click_x, click_y}), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        issue(8'h30, 8'h00); push(8'h30);
        wait_idle(50);

        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
`ifdef SNAKE_RX_ERRCNT_EN
        chk("err_cnt_final", 32'(err_cnt), 32'((exp_errs > 255) ? 255 : exp_errs));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snake_msg_rx.md
Name: snake_msg_rx

Overview:
Receive-side message decoder for the two-board SnakeWars link. It drains bytes from the UART receive FIFO and parses the opcode framing (00 error, 01 direction, 10 collision, 11 click). It emits one-cycle event pulses with decoded payloads toward the game logic. It is the counterpart of the message encoder that frames outgoing moves, collisions and clicks.

Parameters:
TIMEOUT_CYCLES, 100000, max clk cycles to wait for the second byte of a click message; legal range 2..2^24.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
en  in  1  decode enable; when 0, bytes are drained and discarded
rx_empty  in  1  UART RX FIFO empty flag
r_data  in  8  UART RX FIFO head byte; valid while rx_empty=0
rd_uart  out  1  FIFO pop strobe, one cycle per byte
dir_out  out  direction (snake_pkg)  last received direction
dir_valid  out  1  pulse: new direction received
coll_code  out  2  collision code
coll_valid  out  1  pulse: collision message received
click_x  out  6  click X coordinate
click_y  out  8  click Y coordinate
click_valid  out  1  pulse: complete click message received
err  out  1  pulse: opcode 00 received, or click timeout
busy  out  1  high while not in IDLE

Behaviour:
- All outputs are registered. On rst=0, asynchronously: rd_uart=0, all *_valid=0, err=0, busy=0, dir_out=NONE, coll_code=0, click_x=0, click_y=0, timeout counter=0, FSM=IDLE.
- Byte format: [7:6] opcode, [5:0] payload. A click message has two bytes: byte 1 has opcode 11 and payload = x; byte 2 is raw y[7:0] with no opcode.
- FSM states: IDLE, POP_HDR, WAIT_Y, POP_Y.
- IDLE: when rx_empty=0, latch r_data into hdr and go to POP_HDR.
- POP_HDR: rd_uart=1 for exactly this cycle, then decode hdr:
  - 01: dir_out<=direction'(hdr[5:0]); dir_valid pulse; go to IDLE.
  - 10: coll_code<=hdr[1:0]; coll_valid pulse; go to IDLE.
  - 00: err pulse; go to IDLE.
  - 11: latch x<=hdr[5:0]; clear timeout counter; go to WAIT_Y.
- WAIT_Y: when rx_empty=0, latch r_data as y and go to POP_Y. Otherwise increment the counter; when the counter reaches TIMEOUT_CYCLES-1 with rx_empty still 1, pulse err next cycle and go to IDLE. No click is emitted and x is discarded.
- POP_Y: rd_uart=1 for one cycle; click_x<=x, click_y<=y; click_valid pulse; go to IDLE.
- Latency: byte visible in IDLE at cycle N; rd_uart high at N+1; event pulse at N+2. Sustained throughput is one single-byte message per 2 cycles; IDLE samples the FIFO flag after the pop has taken effect.
- rd_uart never asserts while rx_empty=1, and never on two consecutive cycles.
- Event pulses last exactly one cycle. At most one of dir_valid, coll_valid, click_valid, err is high in any cycle.
- dir_out, coll_code, click_x and click_y hold their values between pulses.
- en=0: the FSM still pops and parses (a click still consumes 2 bytes), but all pulses and output-register updates are suppressed. en is sampled on the cycle the pulse would fire.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
- Reset mid-message clears the FSM to IDLE. A partially received click is dropped; its second byte is later parsed as a header.

Optional Feature:
SNAKE_RX_ERRCNT_EN
- Defined: adds output err_cnt [7:0], reset to 0. It increments on every err pulse, including pulses suppressed by en=0, and saturates at 255.
- Not defined: no err_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- FIFO holds 0x44 (opcode 01, payload 4), en=1 -> rd_uart one pulse; dir_valid one pulse 2 cycles after the byte is visible; dir_out=direction'(6'd4); FIFO empty afterwards.
- Bytes 0x82 then 0x00 back-to-back -> coll_valid with coll_code=2'b10, then err pulse; exactly 2 rd_uart pulses; never 2 consecutive cycles of rd_uart.
- Click 0xC5 then 0x20 (second byte arriving 50 cycles later) -> click_valid once, click_x=5, click_y=0x20; busy high from POP_HDR until click_valid.
- TIMEOUT_CYCLES=16: 0xC1 followed by silence -> err pulse 16-17 cycles after entering WAIT_Y, no click_valid; a following 0x41 decodes as direction 1.
- en=0 with 0x43, 0xC2, 0x10 queued -> 3 rd_uart pulses, no pulses, dir_out stays NONE; with SNAKE_RX_ERRCNT_EN, 260 bytes of 0x00 -> err_cnt=255.
- rst asserted during WAIT_Y, mid-click -> all outputs return to reset values immediately without waiting for clk; after release, byte 0x30 is parsed as a header (opcode 00) -> err pulse.
